// File: rtl/sap1_controller_sequencer_pkg.sv
// Shared constants for the SAP-1 controller-sequencer: opcodes, control-word bit positions,
// ring states and the fixed control words used by the decode.
package sap1_controller_sequencer_pkg;

  localparam int NUM_T = 6;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CON_C_P     = 11;
  localparam int CON_E_P     = 10;
  localparam int CON_L_M_BAR = 9;
  localparam int CON_CE_BAR  = 8;
  localparam int CON_L_I_BAR = 7;
  localparam int CON_E_I_BAR = 6;
  localparam int CON_L_A_BAR = 5;
  localparam int CON_E_A     = 4;
  localparam int CON_S_U     = 3;
  localparam int CON_E_U     = 2;
  localparam int CON_L_B_BAR = 1;
  localparam int CON_L_O_BAR = 0;

  // Every line at its inactive level.
  localparam logic [11:0] CON_NOP      = 12'h3E3;
  localparam logic [11:0] CON_FETCH1   = 12'h5E3;
  localparam logic [11:0] CON_FETCH2   = 12'hBE3;
  localparam logic [11:0] CON_FETCH3   = 12'h263;
  localparam logic [11:0] CON_IR_ADDR  = 12'h1A3;
  localparam logic [11:0] CON_RAM_TO_A = 12'h2C3;
  localparam logic [11:0] CON_RAM_TO_B = 12'h2E1;
  localparam logic [11:0] CON_ADD_TO_A = 12'h3C7;
  localparam logic [11:0] CON_SUB_TO_A = 12'h3CF;
  localparam logic [11:0] CON_A_TO_OUT = 12'h3F2;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  function automatic logic is_onehot6(input logic [5:0] t);
    return (t != 6'd0) && ((t & (t - 6'd1)) == 6'd0);
  endfunction

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T1..T6 ring advanced on the falling CLK edge, with synchronous CLR_bar,
// an advance enable (dropped while halted) and a load-T1 input for early instruction end.
module sap1_ring_counter
  import sap1_controller_sequencer_pkg::*;
#(
  parameter int NUM_T_STATES = 6
) (
  input  logic       CLK,
  input  logic       CLR_bar,
  input  logic       advance,
  input  logic       load_t1,
  output logic [5:0] T
);

  if (NUM_T_STATES != NUM_T) begin : g_bad_ring_length
    $error("sap1_ring_counter: NUM_T_STATES must be 6");
  end

  t_state_e state, state_next;

  always_ff @(negedge CLK) begin
    if (!CLR_bar) state <= T1;
    else          state <= state_next;
  end

  always_comb begin
    state_next = T1;
    case (state)
      T1:      state_next = T2;
      T2:      state_next = T3;
      T3:      state_next = T4;
      T4:      state_next = T5;
      T5:      state_next = T6;
      T6:      state_next = T1;
      default: state_next = T1;
    endcase
    // A corrupted ring always recovers to T1, even while holding.
    if (load_t1)
      state_next = T1;
    else if (!advance && is_onehot6(state))
      state_next = state;
  end

  assign T = state;

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller-sequencer: ring state plus opcode decoded into the 12-bit control word
// and the halt request. Define SAP1_EARLY_END_EN to end LDA/OUT/undefined instructions early.
module sap1_controller_sequencer
  import sap1_controller_sequencer_pkg::*;
#(
  parameter int NUM_T_STATES = 6
) (
  input  logic        CLK,
  input  logic        CLR_bar,
  input  logic [3:0]  opcode,
  output logic [11:0] con,
  output logic        HLT_bar,
  output logic [5:0]  T
);

  logic halted, hlt_req, halt, load_t1;

  assign hlt_req = (T == T4) && (opcode == OP_HLT);
  assign halt    = halted || hlt_req;

  // Once HLT is seen the halt is held here, so later opcode changes cannot release it.
  always_ff @(negedge CLK) begin
    if (!CLR_bar)     halted <= 1'b0;
    else if (hlt_req) halted <= 1'b1;
  end

`ifdef SAP1_EARLY_END_EN
  always_comb begin
    load_t1 = 1'b0;
    if ((T == T5) && (opcode == OP_LDA))
      load_t1 = 1'b1;
    else if ((T == T4) && !(opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_HLT}))
      load_t1 = 1'b1;
  end
`else
  assign load_t1 = 1'b0;
`endif

  sap1_ring_counter #(
    .NUM_T_STATES(NUM_T_STATES)
  ) u_ring (
    .CLK    (CLK),
    .CLR_bar(CLR_bar),
    .advance(!halt),
    .load_t1(load_t1),
    .T      (T)
  );

  always_comb begin
    con     = CON_NOP;
    HLT_bar = 1'b1;
    if (!CLR_bar) begin
      con     = CON_NOP;
      HLT_bar = 1'b1;
    end else if (halt) begin
      HLT_bar = 1'b0;
    end else begin
      case (T)
        T1: con = CON_FETCH1;
        T2: con = CON_FETCH2;
        T3: con = CON_FETCH3;
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: con = CON_IR_ADDR;
            OP_OUT:                 con = CON_A_TO_OUT;
            default:                con = CON_NOP;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA:         con = CON_RAM_TO_A;
            OP_ADD, OP_SUB: con = CON_RAM_TO_B;
            default:        con = CON_NOP;
          endcase
        end
        T6: begin
          case (opcode)
            OP_ADD:  con = CON_ADD_TO_A;
            OP_SUB:  con = CON_SUB_TO_A;
            default: con = CON_NOP;
          endcase
        end
        default: con = CON_NOP;
      endcase
    end
  end

endmodule
